// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the T-state sequencer: state enum, opcode patterns,
// register codes, bus-cycle encodings and the register-file strobe bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST, S_M1_T1, S_M1_T2, S_M1_T3, S_M1_T4, S_M1_T5,
        S_M2_T1, S_M2_T2, S_M2_T3, S_TW, S_HALT
    } state_t;

    typedef enum logic [2:0] {K_NOP, K_MOV, K_MVI, K_HLT, K_ILL} op_kind_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] MOV_MASK = 8'hC0;
    localparam logic [7:0] MOV_VAL  = 8'h40;
    localparam logic [7:0] MVI_MASK = 8'hC7;
    localparam logic [7:0] MVI_VAL  = 8'h06;

    localparam logic [2:0] REG_B = 3'b000;
    localparam logic [2:0] REG_C = 3'b001;
    localparam logic [2:0] REG_D = 3'b010;
    localparam logic [2:0] REG_E = 3'b011;
    localparam logic [2:0] REG_H = 3'b100;
    localparam logic [2:0] REG_L = 3'b101;
    localparam logic [2:0] REG_M = 3'b110;
    localparam logic [2:0] REG_A = 3'b111;

    localparam logic [1:0] MC_NONE = 2'd0;
    localparam logic [1:0] MC_M1   = 2'd1;
    localparam logic [1:0] MC_M2   = 2'd2;

    localparam logic [2:0] TS_NONE = 3'd0;
    localparam logic [2:0] TS_T1   = 3'd1;
    localparam logic [2:0] TS_T2   = 3'd2;
    localparam logic [2:0] TS_T3   = 3'd3;
    localparam logic [2:0] TS_T4   = 3'd4;
    localparam logic [2:0] TS_T5   = 3'd5;
    localparam logic [2:0] TS_TW   = 3'd7;

    typedef struct packed {
        logic bc_rw;
        logic de_rw;
        logic hl_rw;
        logic lreg_rd;
        logic rreg_rd;
        logic lreg_wr;
        logic rreg_wr;
        logic sel_alu_a;
        logic alu_a_to_dbus;
        logic dbus_to_act;
        logic alu_to_a;
    } reg_strobe_t;

    // Code 110 is the memory operand, which this sequencer does not support.
    function automatic op_kind_t classify(input logic [7:0] op);
        op_kind_t k;
        k = K_ILL;
        if (op == OP_NOP)
            k = K_NOP;
        else if (op == OP_HLT)
            k = K_HLT;
        else if ((op & MOV_MASK) == MOV_VAL && op[5:3] != REG_M && op[2:0] != REG_M)
            k = K_MOV;
        else if ((op & MVI_MASK) == MVI_VAL && op[5:3] != REG_M)
            k = K_MVI;
        return k;
    endfunction

endpackage

// File: rtl/tstate_sequencer_if.sv
// Control bundle between the sequencer (master) and the 8085 datapath (slave):
// instruction/ready inputs plus every register-file, ALU and bus strobe.
interface tstate_sequencer_if;
    logic [7:0] instr;
    logic       ready;
    logic bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw;
    logic lreg_rd, rreg_rd, lreg_wr, rreg_wr;
    logic dreg_wr, dreg_rd, dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2;
    logic dbus_to_instr_reg;
    logic select_op1, select_op2, select_neg, select_ncarry_1, select_shift_right, shift_right_in;
    logic dbus_to_act, a_to_act, alu_to_a, sel_alu_a, alu_a_to_dbus, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act;
    logic ale, rd_n, halted, illegal;
    logic [1:0] m_cycle;
    logic [2:0] t_state;

    modport master (
        input  instr, ready,
        output bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw,
        output lreg_rd, rreg_rd, lreg_wr, rreg_wr,
        output dreg_wr, dreg_rd, dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2,
        output dbus_to_instr_reg,
        output select_op1, select_op2, select_neg, select_ncarry_1, select_shift_right, shift_right_in,
        output dbus_to_act, a_to_act, alu_to_a, sel_alu_a, alu_a_to_dbus, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act,
        output ale, rd_n, halted, illegal, m_cycle, t_state
    );

    modport slave (
        output instr, ready,
        input  bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw,
        input  lreg_rd, rreg_rd, lreg_wr, rreg_wr,
        input  dreg_wr, dreg_rd, dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2,
        input  dbus_to_instr_reg,
        input  select_op1, select_op2, select_neg, select_ncarry_1, select_shift_right, shift_right_in,
        input  dbus_to_act, a_to_act, alu_to_a, sel_alu_a, alu_a_to_dbus, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act,
        input  ale, rd_n, halted, illegal, m_cycle, t_state
    );
endinterface

// File: rtl/reg_sel_decode.sv
// Maps a 3-bit register code plus read/write enables onto pair-select, byte and A-path strobes.
// Combinational, zero latency; no flow control.
module reg_sel_decode
    import ctrl_pkg::*;
(
    input  logic [2:0]  code,
    input  logic        rd_en,
    input  logic        wr_en,
    output reg_strobe_t strb
);
    always_comb begin
        strb = '0;
        case (code)
            REG_B, REG_C: strb.bc_rw = rd_en | wr_en;
            REG_D, REG_E: strb.de_rw = rd_en | wr_en;
            REG_H, REG_L: strb.hl_rw = rd_en | wr_en;
            REG_A: begin
                strb.sel_alu_a     = rd_en;
                strb.alu_a_to_dbus = rd_en;
                strb.dbus_to_act   = wr_en;
                strb.alu_to_a      = wr_en;
            end
            default: ;
        endcase
        // Accumulator code is odd but lives outside the pair file, so it is excluded here.
        if (code != REG_M && code != REG_A) begin
            strb.lreg_rd = rd_en & ~code[0];
            strb.rreg_rd = rd_en &  code[0];
            strb.lreg_wr = wr_en & ~code[0];
            strb.rreg_wr = wr_en &  code[0];
        end
    end
endmodule

// File: rtl/tstate_sequencer.sv
// 8085 T-state sequencer for NOP/MOV/MVI/HLT; outputs are Moore decodes of state (+instr), zero latency.
// Backpressure: memory ready low at end of T2/TW holds in TW (only with WAIT_STATE_EN; otherwise ready is ignored).
module tstate_sequencer
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    tstate_sequencer_if.master bus
);
    state_t      state;
    op_kind_t    kind;
    reg_strobe_t rd_s, wr_s, rs;
    logic        rd_en, wr_en, mov_t5;
    logic        pc_rw, dreg_wr, dreg_rd, dreg_step, ale, rd_n;
    logic        dbus_to_instr_reg, write_tmp, fe_0_to_act, halted, illegal;
    logic [1:0]  m_cycle;
    logic [2:0]  t_state;

    assign kind = classify(bus.instr);

`ifdef WAIT_STATE_EN
    logic wait_m2;
`else
    logic unused_ready;
    assign unused_ready = bus.ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RST;
`ifdef WAIT_STATE_EN
            wait_m2 <= 1'b0;
`endif
        end else begin
            case (state)
                S_RST:   state <= S_M1_T1;
                S_M1_T1: state <= S_M1_T2;
`ifdef WAIT_STATE_EN
                S_M1_T2: begin
                    state   <= bus.ready ? S_M1_T3 : S_TW;
                    wait_m2 <= 1'b0;
                end
                S_M2_T2: begin
                    state   <= bus.ready ? S_M2_T3 : S_TW;
                    wait_m2 <= 1'b1;
                end
                S_TW: if (bus.ready) state <= wait_m2 ? S_M2_T3 : S_M1_T3;
`else
                S_M1_T2: state <= S_M1_T3;
                S_M2_T2: state <= S_M2_T3;
                S_TW:    state <= S_M1_T1;
`endif
                S_M1_T3: state <= S_M1_T4;
                S_M1_T4: begin
                    case (kind)
                        K_MOV:   state <= S_M1_T5;
                        K_MVI:   state <= S_M2_T1;
                        K_HLT:   state <= S_HALT;
                        default: state <= S_M1_T1;
                    endcase
                end
                S_M1_T5: state <= S_M1_T1;
                S_M2_T1: state <= S_M2_T2;
                S_M2_T3: state <= S_M1_T1;
                S_HALT:  state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Source register is read in MOV T4; destination written in MOV T5 or MVI M2 T3.
    assign rd_en  = (state == S_M1_T4) && (kind == K_MOV);
    assign mov_t5 = (state == S_M1_T5);
    assign wr_en  = mov_t5 || (state == S_M2_T3);

    reg_sel_decode u_rd_dec (.code(bus.instr[2:0]), .rd_en(rd_en),  .wr_en(1'b0),  .strb(rd_s));
    reg_sel_decode u_wr_dec (.code(bus.instr[5:3]), .rd_en(1'b0),   .wr_en(wr_en), .strb(wr_s));
    assign rs = rd_s | wr_s;

    always_comb begin
        pc_rw = 1'b0; dreg_wr = 1'b0; dreg_rd = 1'b0; dreg_step = 1'b0;
        ale = 1'b0; rd_n = 1'b1; dbus_to_instr_reg = 1'b0;
        write_tmp = 1'b0; fe_0_to_act = 1'b0; halted = 1'b0; illegal = 1'b0;
        m_cycle = MC_NONE; t_state = TS_NONE;
        case (state)
            S_M1_T1, S_M2_T1: begin
                pc_rw = 1'b1; dreg_wr = 1'b1; ale = 1'b1; t_state = TS_T1;
                m_cycle = (state == S_M2_T1) ? MC_M2 : MC_M1;
            end
            S_M1_T2, S_M2_T2: begin
                pc_rw = 1'b1; dreg_rd = 1'b1; dreg_step = 1'b1; rd_n = 1'b0; t_state = TS_T2;
                m_cycle = (state == S_M2_T2) ? MC_M2 : MC_M1;
            end
            S_M1_T3: begin
                rd_n = 1'b0; dbus_to_instr_reg = 1'b1; t_state = TS_T3; m_cycle = MC_M1;
            end
            S_M2_T3: begin
                rd_n = 1'b0; t_state = TS_T3; m_cycle = MC_M2;
            end
            S_M1_T4: begin
                t_state = TS_T4; m_cycle = MC_M1;
                illegal     = (kind == K_ILL);
                write_tmp   = (kind == K_MOV);
                fe_0_to_act = (kind == K_MOV);
            end
            S_M1_T5: begin
                t_state = TS_T5; m_cycle = MC_M1;
            end
            S_TW: begin
                rd_n = 1'b0; t_state = TS_TW;
`ifdef WAIT_STATE_EN
                m_cycle = wait_m2 ? MC_M2 : MC_M1;
`else
                m_cycle = MC_M1;
`endif
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.bc_rw   = rs.bc_rw;
    assign bus.de_rw   = rs.de_rw;
    assign bus.hl_rw   = rs.hl_rw;
    assign bus.lreg_rd = rs.lreg_rd;
    assign bus.rreg_rd = rs.rreg_rd;
    assign bus.lreg_wr = rs.lreg_wr;
    assign bus.rreg_wr = rs.rreg_wr;
    assign bus.pc_rw   = pc_rw;
    assign bus.dreg_wr  = dreg_wr;
    assign bus.dreg_rd  = dreg_rd;
    assign bus.dreg_inc = dreg_step;
    assign bus.dreg_cnt = dreg_step;
    assign bus.dbus_to_instr_reg     = dbus_to_instr_reg;
    assign bus.select_op1            = mov_t5;
    assign bus.dbus_to_act           = rs.dbus_to_act;
    assign bus.alu_to_a              = rs.alu_to_a;
    assign bus.sel_alu_a             = rs.sel_alu_a;
    assign bus.alu_a_to_dbus         = rs.alu_a_to_dbus | mov_t5;
    assign bus.write_dbus_to_alu_tmp = write_tmp;
    assign bus.fe_0_to_act           = fe_0_to_act;
    assign bus.sel_0_fe              = 1'b0;
    assign bus.ale     = ale;
    assign bus.rd_n    = rd_n;
    assign bus.m_cycle = m_cycle;
    assign bus.t_state = t_state;
    assign bus.halted  = halted;
    assign bus.illegal = illegal;

    // Strobes not used by the supported opcode subset are tied low.
    assign bus.wz_rw = 1'b0;
    assign bus.sp_rw = 1'b0;
    assign bus.dreg_dec  = 1'b0;
    assign bus.dreg_cnt2 = 1'b0;
    assign bus.select_op2 = 1'b0;
    assign bus.select_neg = 1'b0;
    assign bus.select_ncarry_1    = 1'b0;
    assign bus.select_shift_right = 1'b0;
    assign bus.shift_right_in     = 1'b0;
    assign bus.a_to_act = 1'b0;
endmodule

// File: tb/tb_tstate_sequencer.sv
// Scoreboard bench for tstate_sequencer: stimulus pushes one hand-built expected vector per
// cycle; a negedge monitor pops and compares the full observed output vector.
module tb_tstate_sequencer;
    typedef struct packed {
        logic [2:0] ts;
        logic [1:0] mc;
        logic halted, illegal, ale, rd_n;
        logic pc_rw, dreg_wr, dreg_rd, dreg_inc, dreg_cnt, dbus_to_instr_reg;
        logic bc_rw, de_rw, hl_rw, lreg_rd, rreg_rd, lreg_wr, rreg_wr;
        logic sel_alu_a, alu_a_to_dbus, dbus_to_act, alu_to_a, write_tmp, fe_0_to_act, sel_0_fe, select_op1;
        logic [9:0] rsv;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    tstate_sequencer_if bus();
    tstate_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    obs_t  obs;
    obs_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always_comb begin
        obs = '0;
        obs.ts = bus.t_state; obs.mc = bus.m_cycle;
        obs.halted = bus.halted; obs.illegal = bus.illegal; obs.ale = bus.ale; obs.rd_n = bus.rd_n;
        obs.pc_rw = bus.pc_rw; obs.dreg_wr = bus.dreg_wr; obs.dreg_rd = bus.dreg_rd;
        obs.dreg_inc = bus.dreg_inc; obs.dreg_cnt = bus.dreg_cnt; obs.dbus_to_instr_reg = bus.dbus_to_instr_reg;
        obs.bc_rw = bus.bc_rw; obs.de_rw = bus.de_rw; obs.hl_rw = bus.hl_rw;
        obs.lreg_rd = bus.lreg_rd; obs.rreg_rd = bus.rreg_rd; obs.lreg_wr = bus.lreg_wr; obs.rreg_wr = bus.rreg_wr;
        obs.sel_alu_a = bus.sel_alu_a; obs.alu_a_to_dbus = bus.alu_a_to_dbus;
        obs.dbus_to_act = bus.dbus_to_act; obs.alu_to_a = bus.alu_to_a;
        obs.write_tmp = bus.write_dbus_to_alu_tmp; obs.fe_0_to_act = bus.fe_0_to_act;
        obs.sel_0_fe = bus.sel_0_fe; obs.select_op1 = bus.select_op1;
        obs.rsv = {bus.select_op2, bus.select_neg, bus.select_ncarry_1, bus.select_shift_right,
                   bus.shift_right_in, bus.a_to_act, bus.sp_rw, bus.wz_rw, bus.dreg_dec, bus.dreg_cnt2};
    end

    always @(negedge clk) begin : monitor
        obs_t  e;
        string n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", n, obs, e);
            end
        end
    end

    function automatic obs_t e_idle(input logic [2:0] ts, input logic [1:0] mc);
        obs_t e;
        e = '0;
        e.rd_n = 1'b1; e.ts = ts; e.mc = mc;
        return e;
    endfunction

    function automatic obs_t e_t1(input logic [1:0] mc);
        obs_t e;
        e = e_idle(3'd1, mc);
        e.pc_rw = 1'b1; e.dreg_wr = 1'b1; e.ale = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_t2(input logic [1:0] mc);
        obs_t e;
        e = e_idle(3'd2, mc);
        e.pc_rw = 1'b1; e.dreg_rd = 1'b1; e.dreg_inc = 1'b1; e.dreg_cnt = 1'b1; e.rd_n = 1'b0;
        return e;
    endfunction

    function automatic obs_t e_t3(input logic [1:0] mc);
        obs_t e;
        e = e_idle(3'd3, mc);
        e.rd_n = 1'b0;
        e.dbus_to_instr_reg = (mc == 2'd1);
        return e;
    endfunction

    function automatic obs_t e_tw(input logic [1:0] mc);
        obs_t e;
        e = e_idle(3'd7, mc);
        e.rd_n = 1'b0;
        return e;
    endfunction

    task automatic step(input string name, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step({tag, "_t1"}, e_t1(2'd1));
        step({tag, "_t2"}, e_t2(2'd1));
        step({tag, "_t3"}, e_t3(2'd1));
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        obs_t e;
        rst = 1'b1; bus.instr = 8'h00; bus.ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step("reset", e_idle(3'd0, 2'd0));
        rst = 1'b0;
        step("rst_release", e_idle(3'd0, 2'd0));

        // NOP
        fetch("nop");
        step("nop_t4", e_idle(3'd4, 2'd1));

        // MOV D,B
        bus.instr = 8'h50;
        fetch("movdb");
        e = e_idle(3'd4, 2'd1); e.bc_rw = 1; e.lreg_rd = 1; e.write_tmp = 1; e.fe_0_to_act = 1;
        step("movdb_t4", e);
        e = e_idle(3'd5, 2'd1); e.de_rw = 1; e.lreg_wr = 1; e.select_op1 = 1; e.alu_a_to_dbus = 1;
        step("movdb_t5", e);

        // MOV A,E
        bus.instr = 8'h7B;
        step("movdb_next_t1", e_t1(2'd1));
        step("movae_t2", e_t2(2'd1));
        step("movae_t3", e_t3(2'd1));
        e = e_idle(3'd4, 2'd1); e.de_rw = 1; e.rreg_rd = 1; e.write_tmp = 1; e.fe_0_to_act = 1;
        step("movae_t4", e);
        e = e_idle(3'd5, 2'd1); e.dbus_to_act = 1; e.alu_to_a = 1; e.select_op1 = 1; e.alu_a_to_dbus = 1;
        step("movae_t5", e);

        // MOV C,A
        bus.instr = 8'h4F;
        fetch("movca");
        e = e_idle(3'd4, 2'd1); e.sel_alu_a = 1; e.alu_a_to_dbus = 1; e.write_tmp = 1; e.fe_0_to_act = 1;
        step("movca_t4", e);
        e = e_idle(3'd5, 2'd1); e.bc_rw = 1; e.rreg_wr = 1; e.select_op1 = 1; e.alu_a_to_dbus = 1;
        step("movca_t5", e);

        // MVI L,d8
        bus.instr = 8'h2E;
        fetch("mvil");
        step("mvil_t4", e_idle(3'd4, 2'd1));
        step("mvil_m2t1", e_t1(2'd2));
        step("mvil_m2t2", e_t2(2'd2));
        e = e_t3(2'd2); e.hl_rw = 1; e.rreg_wr = 1;
        step("mvil_m2t3", e);

        // ready low for two samples at end of M1 T2
        bus.instr = 8'h00;
        step("wait_t1", e_t1(2'd1));
        bus.ready = 1'b0;
        step("wait_t2", e_t2(2'd1));
`ifdef WAIT_STATE_EN
        step("wait_tw1", e_tw(2'd1));
        bus.ready = 1'b1;
        step("wait_tw2", e_tw(2'd1));
        step("wait_t3", e_t3(2'd1));
        step("wait_t4", e_idle(3'd4, 2'd1));
        // one wait state inside M2 of MVI B
        bus.instr = 8'h06;
        fetch("mvib");
        step("mvib_t4", e_idle(3'd4, 2'd1));
        step("mvib_m2t1", e_t1(2'd2));
        bus.ready = 1'b0;
        step("mvib_m2t2", e_t2(2'd2));
        bus.ready = 1'b1;
        step("mvib_m2tw", e_tw(2'd2));
        e = e_t3(2'd2); e.bc_rw = 1; e.lreg_wr = 1;
        step("mvib_m2t3", e);
`else
        step("noready_t3", e_t3(2'd1));
        bus.ready = 1'b1;
        step("noready_t4", e_idle(3'd4, 2'd1));
`endif

        // Unsupported opcodes: JMP, MOV B,M, MVI M
        bus.instr = 8'hC3;
        fetch("ill_c3");
        e = e_idle(3'd4, 2'd1); e.illegal = 1;
        step("ill_c3_t4", e);
        bus.instr = 8'h46;
        fetch("ill_46");
        step("ill_46_t4", e);
        bus.instr = 8'h36;
        fetch("ill_36");
        step("ill_36_t4", e);

        // Reset during M2 T2 of MVI A
        bus.instr = 8'h3E;
        fetch("mvia");
        step("mvia_t4", e_idle(3'd4, 2'd1));
        step("mvia_m2t1", e_t1(2'd2));
        rst = 1'b1;
        step("mvia_m2t2_rst", e_t2(2'd2));
        rst = 1'b0;
        step("mvia_abort_rst", e_idle(3'd0, 2'd0));

        // HLT, then reset out of HALT
        bus.instr = 8'h76;
        fetch("hlt");
        step("hlt_t4", e_idle(3'd4, 2'd1));
        e = e_idle(3'd0, 2'd0); e.halted = 1;
        for (int i = 0; i < 10; i++) step("halted", e);
        rst = 1'b1;
        step("halted_rst_asserted", e);
        rst = 1'b0;
        step("halt_exit_rst", e_idle(3'd0, 2'd0));
        bus.instr = 8'h00;
        step("post_halt_t1", e_t1(2'd1));

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
